// File: rtl/io_bank_if.sv
// rtl/io_bank_if.sv - MMU I/O port request/response bundle
interface io_bank_if;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;

    modport master (
        output io_addr, io_en, io_we, io_data_write,
        input  io_data_read
    );

    modport slave (
        input  io_addr, io_en, io_we, io_data_write,
        output io_data_read
    );
endinterface

// File: rtl/io_bank.sv
// rtl/io_bank.sv - I/O window responder: GPIO, compare timer, UART TX with FIFO
module io_bank #(
    parameter int CLKS_PER_BIT   = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_DEPTH_LOG = 2
) (
    input  logic       clk,
    input  logic       resetb,
    io_bank_if.slave   io,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out,
    output logic       uart_tx,
    output logic       irq
);
    localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNTW = FIFO_DEPTH_LOG + 1;

    localparam logic [CW-1:0]             BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]             CLK_ONE  = CW'(1);
    localparam logic [CNTW-1:0]           DEPTH_V  = CNTW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0]           CNT_ONE  = CNTW'(1);
    localparam logic [FIFO_DEPTH_LOG-1:0] PTR_ONE  = FIFO_DEPTH_LOG'(1);

    localparam logic [5:0] A_GPIO_OUT  = 6'h00;
    localparam logic [5:0] A_GPIO_IN   = 6'h01;
    localparam logic [5:0] A_TMR_COUNT = 6'h02;
    localparam logic [5:0] A_TMR_CMP   = 6'h03;
    localparam logic [5:0] A_TMR_CTRL  = 6'h04;
    localparam logic [5:0] A_UART_TX   = 6'h05;
    localparam logic [5:0] A_UART_STAT = 6'h06;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    logic [5:0]  word;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic        addr_unused;

    assign word        = io.io_addr[7:2];
    assign wr          = io.io_en & io.io_we;
    assign rd          = io.io_en & ~io.io_we;
    assign wdata       = io.io_data_write;
    assign addr_unused = ^io.io_addr[1:0];

    // GPIO output register and two-flop input synchronizer
    logic [7:0] gpio_out_q;
    logic [7:0] sync1;
    logic [7:0] sync2;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            gpio_out_q <= 8'h0;
            sync1      <= 8'h0;
            sync2      <= 8'h0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            if (wr && word == A_GPIO_OUT)
                gpio_out_q <= wdata[7:0];
        end
    end

    assign gpio_out = gpio_out_q;

    // Compare timer
    logic [31:0] tmr_count;
    logic [31:0] tmr_cmp;
    logic        tmr_en;
    logic        tmr_irq_en;
    logic        tmr_flag;
    logic        irq_q;
    logic        ctrl_wr;
    logic        tmr_match;
    logic        flag_nxt;
    logic        irq_en_nxt;

    assign ctrl_wr    = wr && word == A_TMR_CTRL;
    assign tmr_match  = tmr_en && (tmr_count == tmr_cmp);
    assign irq_en_nxt = ctrl_wr ? wdata[1] : tmr_irq_en;
    // A match landing on the same edge as a W1C keeps the flag set
    assign flag_nxt   = tmr_match | (tmr_flag & ~(ctrl_wr & wdata[2]));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            tmr_count  <= 32'h0;
            tmr_cmp    <= 32'h0;
            tmr_en     <= 1'b0;
            tmr_irq_en <= 1'b0;
            tmr_flag   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (wr && word == A_TMR_COUNT)
                tmr_count <= wdata;
            else if (tmr_match)
                tmr_count <= 32'h0;
            else if (tmr_en)
                tmr_count <= tmr_count + 32'd1;
            if (wr && word == A_TMR_CMP)
                tmr_cmp <= wdata;
            if (ctrl_wr)
                tmr_en <= wdata[0];
            tmr_irq_en <= irq_en_nxt;
            tmr_flag   <= flag_nxt;
            irq_q      <= flag_nxt & irq_en_nxt;
        end
    end

    assign irq = irq_q;

    // UART TX FIFO
    tx_state_t                 state;
    tx_state_t                 state_nxt;
    logic [7:0]                fifo_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
    logic [CNTW-1:0]           fifo_cnt;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      tx_wr;
    logic                      push;
    logic                      pop;
    logic                      tx_ovf;

    assign fifo_full  = fifo_cnt == DEPTH_V;
    assign fifo_empty = fifo_cnt == '0;
    assign tx_wr      = wr && word == A_UART_TX;
    assign pop        = (state == S_IDLE) && !fifo_empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands
    assign push       = tx_wr && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            tx_ovf   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: ;
            endcase
            if (tx_wr && fifo_full && !pop)
                tx_ovf <= 1'b1;
            else if (wr && word == A_UART_STAT && wdata[4])
                tx_ovf <= 1'b0;
        end
    end

    // Serializer
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_byte;
    logic          bit_done;
    logic          busy;

    assign bit_done = clk_cnt == BIT_LAST;
    assign busy     = state != S_IDLE;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        uart_tx   = 1'b1;
        case (state)
            S_IDLE: begin
                if (pop)
                    state_nxt = S_START;
            end
            S_START: begin
                uart_tx = 1'b0;
                if (bit_done)
                    state_nxt = S_DATA;
            end
            S_DATA: begin
                uart_tx = tx_byte[bit_idx];
                if (bit_done && bit_idx == 3'd7)
                    state_nxt = S_STOP;
            end
            S_STOP: begin
                if (bit_done)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            tx_byte <= 8'h0;
        end else if (state == S_IDLE) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            if (pop)
                tx_byte <= fifo_mem[rd_ptr];
        end else if (bit_done) begin
            clk_cnt <= '0;
            if (state == S_DATA)
                bit_idx <= bit_idx + 3'd1;
        end else begin
            clk_cnt <= clk_cnt + CLK_ONE;
        end
    end

    // Read mux
    logic [3:0]  cnt_field;
    logic [31:0] rdata;

    assign cnt_field = 4'(fifo_cnt);

    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            case (word)
                A_GPIO_OUT:  rdata = {24'h0, gpio_out_q};
                A_GPIO_IN:   rdata = {24'h0, sync2};
                A_TMR_COUNT: rdata = tmr_count;
                A_TMR_CMP:   rdata = tmr_cmp;
                A_TMR_CTRL:  rdata = {29'h0, tmr_flag, tmr_irq_en, tmr_en};
                A_UART_STAT: rdata = {24'h0, busy, fifo_empty, fifo_full, tx_ovf, cnt_field};
                default:     rdata = 32'h0;
            endcase
        end
    end

    assign io.io_data_read = rdata;
endmodule

// File: tb/tb_io_bank.sv
// tb/tb_io_bank.sv - self-checking bench for io_bank
module tb_io_bank;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic [7:0] gpio_in = 8'h0;
    logic [7:0] gpio_out;
    logic       uart_tx;
    logic       irq;

    io_bank_if bus();

    io_bank #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FIFO_DEPTH_LOG(2)) dut (
        .clk(clk), .resetb(resetb), .io(bus.slave), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .uart_tx(uart_tx), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_write;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] rd;
    logic [31:0] wr_rdata;
    vec_t        vecs[$];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  mfifo[$];
    int          rx_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus.io_addr = a; bus.io_we = 1'b1; bus.io_data_write = d; bus.io_en = 1'b1;
        #2 wr_rdata = bus.io_data_read;
        @(posedge clk); #1;
        bus.io_en = 1'b0; bus.io_we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        bus.io_addr = a; bus.io_we = 1'b0; bus.io_en = 1'b1;
        #2 d = bus.io_data_read;
        @(posedge clk); #1;
        bus.io_en = 1'b0;
    endtask

    task automatic recv_byte(input int timeout, output logic [7:0] b, output bit ok);
        int n;
        n = 0; ok = 1'b0; b = 8'h0;
        @(negedge clk);
        while (uart_tx !== 1'b0 && n < timeout) begin @(negedge clk); n++; end
        if (uart_tx !== 1'b0) return;
        repeat (CPB / 2) @(negedge clk);
        if (uart_tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        ok = (uart_tx === 1'b1);
    endtask

    function automatic logic line_level(input logic [7:0] b, input int k);
        int j;
        if (k <= 0) return 1'b1;
        j = (k - 1) / CPB;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    task automatic timer_run(input logic [31:0] start, input logic [31:0] cmp, input int n);
        logic [31:0] mc;
        logic        mflag;
        logic [31:0] v;
        bus_write(8'h10, 32'h4);
        bus_write(8'h0C, cmp);
        bus_write(8'h08, start);
        bus_write(8'h10, 32'h3);
        mc = start; mflag = 1'b0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("tmr_irq_%0d", i), {31'h0, irq}, {31'h0, mflag});
            bus_read(8'h08, v);
            check($sformatf("tmr_count_%0d", i), v, mc);
            if (mc == cmp) begin mc = 32'h0; mflag = 1'b1; end
            else mc = mc + 32'd1;
        end
    endtask

    initial begin
        logic [31:0] mdl [64];
        logic [7:0]  b;
        bit          ok;
        int          w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp_stat;
        bit          ovf_m;

        bus.io_en = 1'b0; bus.io_we = 1'b0; bus.io_addr = 8'h0; bus.io_data_write = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
        check("rst_rdata_idle", bus.io_data_read, 32'h0);
        resetb = 1'b1;
        idle_cycle();

        vecs.push_back('{1'b0, 8'h18, 32'h0, 32'h40});
        vecs.push_back('{1'b0, 8'h00, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 8'h08, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 8'h0C, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 8'h10, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 8'h14, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 8'h1C, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 8'h0C, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 8'h0C, 32'h0, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 8'h0F, 32'h0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 8'h10, 32'hFFFFFFF8, 32'h0});
        vecs.push_back('{1'b0, 8'h10, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 8'h40, 32'h12345678, 32'h0});
        vecs.push_back('{1'b0, 8'h40, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 8'hFC, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 8'h04, 32'hFF, 32'h0});
        vecs.push_back('{1'b0, 8'h04, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 8'h18, 32'hFFFFFFFF, 32'h0});
        vecs.push_back('{1'b0, 8'h18, 32'h0, 32'h40});
        vecs.push_back('{1'b1, 8'h00, 32'hFFFFFFA5, 32'h0});
        vecs.push_back('{1'b0, 8'h00, 32'h0, 32'hA5});

        foreach (vecs[i]) begin
            if (vecs[i].is_write) begin
                bus_write(vecs[i].addr, vecs[i].data);
                check($sformatf("vec%0d_wr_rdata", i), wr_rdata, 32'h0);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
            end
        end
        check("gpio_out_pin", {24'h0, gpio_out}, 32'hA5);

        gpio_in = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            bus_read(8'h04, rd);
            check($sformatf("gpio_in_sync_%0d", i), rd, (i >= 2) ? 32'h3C : 32'h0);
        end

        // Randomised register traffic against a word-array model
        for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
        mdl[0] = 32'hA5; mdl[3] = 32'hDEADBEEF;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       w = 0;
                1:       w = 2;
                2:       w = 3;
                default: w = $urandom_range(7, 63);
            endcase
            a = {w[5:0], 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                bus_write(a, d);
                if (w == 0) mdl[0] = {24'h0, d[7:0]};
                else if (w == 2 || w == 3) mdl[w] = d;
            end else begin
                bus_read(a, rd);
                check($sformatf("rand_reg_%0d_w%0d", i, w), rd, (w <= 3) ? mdl[w] : 32'h0);
            end
        end

        timer_run(32'h0, 32'h5, 8);
        bus_write(8'h10, 32'h2);
        check("irq_held", {31'h0, irq}, 32'h1);
        bus_read(8'h10, rd);
        check("ctrl_flag_set", rd, 32'h6);
        bus_write(8'h10, 32'h6);
        check("irq_w1c_drop", {31'h0, irq}, 32'h0);
        bus_read(8'h10, rd);
        check("ctrl_flag_clr", rd, 32'h2);
        bus_write(8'h08, 32'h4);
        bus_write(8'h10, 32'h3);
        idle_cycle();
        bus_write(8'h10, 32'h7);
        bus_read(8'h10, rd);
        check("ctrl_set_wins", rd, 32'h7);
        check("irq_set_wins", {31'h0, irq}, 32'h1);
        bus_write(8'h10, 32'h6);
        bus_read(8'h10, rd);
        check("ctrl_after_clr", rd, 32'h2);
        timer_run(32'hFFFFFFFE, 32'h3, 9);
        bus_write(8'h10, 32'h4);

        // Single frame, cycle by cycle
        bus_write(8'h14, 32'h55);
        for (int k = 0; k < 162; k++) begin
            check($sformatf("tx_k%0d", k), {31'h0, uart_tx}, {31'h0, line_level(8'h55, k)});
            bus_read(8'h18, rd);
            if (k == 0) exp_stat = 32'h01;
            else if (k <= 10 * CPB) exp_stat = 32'hC0;
            else exp_stat = 32'h40;
            check($sformatf("stat_k%0d", k), rd, exp_stat);
        end

        // Overflow while a frame is in flight
        got_q.delete(); exp_q.delete(); mfifo.delete(); ovf_m = 1'b0;
        fork
            begin
                logic [7:0] rb;
                bit         rok;
                for (int f = 0; f < 5; f++) begin
                    recv_byte(400, rb, rok);
                    if (!rok) rx_bad++;
                    got_q.push_back(rb);
                end
            end
            begin
                bus_write(8'h14, 32'h11);
                idle_cycle();
                exp_q.push_back(8'h11);
                for (int i = 0; i < 6; i++) begin
                    d = 32'h22 * (i + 1);
                    bus_write(8'h14, d);
                    if (mfifo.size() < DEPTH) mfifo.push_back(d[7:0]);
                    else ovf_m = 1'b1;
                end
                exp_stat = {24'h0, 1'b1, mfifo.size() == 0, mfifo.size() == DEPTH, ovf_m, 4'(mfifo.size())};
                bus_read(8'h18, rd);
                check("stat_full_ovf", rd, exp_stat);
                bus_write(8'h18, 32'h10);
                exp_stat[4] = 1'b0;
                bus_read(8'h18, rd);
                check("stat_ovf_w1c", rd, exp_stat);
                foreach (mfifo[i]) exp_q.push_back(mfifo[i]);
            end
        join
        check("rx_frames_ok", rx_bad, 0);
        check("rx_count", got_q.size(), exp_q.size());
        foreach (exp_q[i])
            check($sformatf("rx_byte_%0d", i), (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFFFFFF, {24'h0, exp_q[i]});
        recv_byte(400, b, ok);
        check("no_extra_frame", {31'h0, ok}, 32'h0);
        bus_read(8'h18, rd);
        check("stat_drained", rd, 32'h40);

        // Random bytes through the serializer
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            fork
                recv_byte(400, b, ok);
                bus_write(8'h14, {24'h0, d[7:0]});
            join
            check($sformatf("rand_rx_ok_%0d", i), {31'h0, ok}, 32'h1);
            check($sformatf("rand_rx_%0d", i), {24'h0, b}, {24'h0, d[7:0]});
        end

        // Reset in the middle of the data bits
        bus_write(8'h14, 32'h00);
        bus_write(8'h14, 32'hAA);
        repeat (60) idle_cycle();
        check("mid_data_low", {31'h0, uart_tx}, 32'h0);
        resetb = 1'b0;
        #1;
        check("rst_mid_tx_high", {31'h0, uart_tx}, 32'h1);
        check("rst_mid_gpio", {24'h0, gpio_out}, 32'h0);
        idle_cycle();
        idle_cycle();
        resetb = 1'b1;
        bus_read(8'h18, rd);
        check("rst_mid_stat", rd, 32'h40);
        w = 0;
        for (int i = 0; i < 200; i++) begin
            if (uart_tx !== 1'b1) w++;
            idle_cycle();
        end
        check("rst_mid_line_idle", w, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
